// File: rtl/f_bist_pkg.sv
// Shared constants, state encoding and LFSR step for the f_bist_ctrl self-test wrapper around cone F.
package f_bist_pkg;

  localparam int VEC_W = 74;
  localparam int SIG_W = 16;

  // Fibonacci taps for x^74 + x^73 + x^59 + x^58 + 1, as a mask over the register.
  localparam logic [VEC_W-1:0] LFSR_TAPS = (74'b1 << 73) | (74'b1 << 72) |
                                           (74'b1 << 58) | (74'b1 << 57);
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  // Position of F's pins within vec: g7 at the top, descending to g145, then t_0.
  localparam int G7_BIT    = 73;
  localparam int G145_BIT  = 1;
  localparam int G_PIN_MSB = G7_BIT;
  localparam int G_PIN_LSB = G145_BIT;
  localparam int T0_BIT    = 0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] s);
    return {s[VEC_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f_bist_misr.sv
// Serial 16-bit MISR compacting F's single response bit; clear wins over enable.
module f_bist_misr
  import f_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ ((sig[SIG_W-1] ^ din) ? MISR_POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/f_bist_ctrl.sv
// BIST controller: LFSR stimulus into cone F, MISR on g217, signature compare at end of run.
// Optional F_BIST_T0_HOLD_EN ties t_0 (vec[0]) to T0_TIE during RUN.
module f_bist_ctrl
  import f_bist_pkg::*;
#(
  parameter int unsigned      N_VEC  = 1024,
  parameter logic [VEC_W-1:0] SEED   = 74'h1,
  parameter logic             T0_TIE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             g217,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_cnt
);

`ifdef F_BIST_T0_HOLD_EN
  localparam bit T0_HOLD = 1'b1;
`else
  localparam bit T0_HOLD = 1'b0;
`endif

  localparam logic [15:0] N_LAST = 16'(N_VEC - 1);

  state_t           state;
  logic [VEC_W-1:0] lfsr;
  logic [VEC_W-1:0] lfsr_nxt;
  logic [SIG_W-1:0] sig_next;
  logic             last;
  logic             misr_clr;
  logic             misr_en;

  // The LFSR itself is never overridden; only the bit presented to F's t_0 is.
  function automatic logic [VEC_W-1:0] drive(input logic [VEC_W-1:0] v);
    return {v[VEC_W-1:1], T0_HOLD ? T0_TIE : v[T0_BIT]};
  endfunction

  always_comb begin
    lfsr_nxt = lfsr_step(lfsr);
    last     = (vec_cnt == N_LAST);
    misr_clr = start && (state != RUN);
    misr_en  = (state == RUN);
  end

  f_bist_misr u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (misr_clr),
    .en       (misr_en),
    .din      (g217),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= '0;
      vec     <= '0;
      vec_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            lfsr    <= SEED;
            vec     <= drive(SEED);
            vec_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          lfsr    <= lfsr_nxt;
          vec_cnt <= vec_cnt + 16'd1;
          if (last) begin
            // pass uses sig_next: this edge also folds in the final vector's response.
            state <= DONE;
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == exp_sig);
          end else begin
            vec <= drive(lfsr_nxt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_bist_ctrl.sv
// Scoreboard bench for f_bist_ctrl: random response functions of vec stand in for cone F.
module tb_f_bist_ctrl;

  localparam int          N     = 16;
  localparam logic [73:0] SEEDV = 74'h1;
  localparam logic        TIE   = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_sig = '0;
  logic        g217;
  logic [73:0] vec;
  logic        busy, done, pass;
  logic [15:0] sig, vec_cnt;

  logic [73:0] mask = '0;
  logic        inv = 1'b0;

  logic        s_start = 1'b0;
  logic [15:0] s_exp = '0;
  logic [73:0] s_vec;
  logic        s_busy, s_done, s_pass;
  logic [15:0] s_sig, s_cnt;

  int applied = 0;
  int miscompares = 0;

  typedef struct { logic [73:0] v; logic [15:0] cnt; } vexp_t;
  typedef struct { logic [15:0] sig; logic pass; } rexp_t;
  vexp_t vq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  // Stand-in for F: parity of a random subset of inputs, optionally inverted.
  assign g217 = (^(vec & mask)) ^ inv;

  f_bist_ctrl #(.N_VEC(N), .SEED(SEEDV), .T0_TIE(TIE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig), .g217(g217),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .sig(sig), .vec_cnt(vec_cnt)
  );

  f_bist_ctrl #(.N_VEC(1), .SEED(74'h5), .T0_TIE(TIE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .exp_sig(s_exp), .g217(1'b1),
    .vec(s_vec), .busy(s_busy), .done(s_done), .pass(s_pass), .sig(s_sig), .vec_cnt(s_cnt)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [73:0] model_next(input logic [73:0] s);
    return {s[72:0], s[73] ^ s[72] ^ s[58] ^ s[57]};
  endfunction

  function automatic logic [73:0] model_drv(input logic [73:0] s);
`ifdef F_BIST_T0_HOLD_EN
    return {s[73:1], TIE};
`else
    return s;
`endif
  endfunction

  // Signature as CRC-CCITT style shift of the response stream.
  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic g);
    logic [15:0] r;
    r = s << 1;
    if (s[15] != g) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"}, 96'(vec), 96'd0);
    chk({tag, "_busy"}, 96'(busy), 96'd0);
    chk({tag, "_done"}, 96'(done), 96'd0);
    chk({tag, "_pass"}, 96'(pass), 96'd0);
    chk({tag, "_sig"}, 96'(sig), 96'd0);
    chk({tag, "_cnt"}, 96'(vec_cnt), 96'd0);
  endtask

  task automatic run(input logic [73:0] m, input logic iv, input bit match,
                     input int pulse_at, input int rst_at);
    logic [73:0] v, d;
    logic [15:0] s;
    logic        g;
    int          k;
    v = SEEDV;
    s = '0;
    for (int i = 1; i <= N; i++) begin
      d = model_drv(v);
      vq.push_back('{d, 16'(i - 1)});
      g = (^(d & m)) ^ iv;
      s = model_misr(s, g);
      v = model_next(v);
    end
    @(posedge clk); #1;
    mask = m;
    inv = iv;
    exp_sig = match ? s : (s ^ 16'($urandom_range(1, 65535)));
    if (rst_at == 0) rq.push_back('{s, match});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (!done && k <= N + 4) begin
      if (rst_at != 0 && k == rst_at + 1) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vq.delete();
        chk_zero("midrun_reset");
        return;
      end
      start = (k == pulse_at);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL run_timeout: done=%0b after %0d cycles, required 1", done, k);
    end
  endtask

  // Monitor: pops expected vectors while busy, results on the rising edge of done.
  logic busy_q = 1'b0, done_q = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    vexp_t ve;
    rexp_t re;
    if (busy) begin
      if (!busy_q) begin
        busy_cnt = 0;
        chk("run_start_sig", 96'(sig), 96'd0);
      end
      busy_cnt++;
      if (vq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_vector: got %h, none expected", vec);
      end else begin
        ve = vq.pop_front();
        chk("vec", 96'(vec), 96'(ve.v));
        chk("vec_cnt", 96'(vec_cnt), 96'(ve.cnt));
      end
    end
    if (done && !done_q) begin
      chk("run_cycles", 96'(busy_cnt), 96'(N));
      chk("done_cnt", 96'(vec_cnt), 96'(N));
      chk("done_vec", 96'(vec), 96'd0);
      chk("done_busy", 96'(busy), 96'd0);
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: sig %h, no result expected", sig);
      end else begin
        re = rq.pop_front();
        chk("sig", 96'(sig), 96'(re.sig));
        chk("pass", 96'(pass), 96'(re.pass));
      end
    end
    busy_q = busy;
    done_q = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [73:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Single-vector instance with g217 tied high.
    s_exp = 16'h1021;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("n1_busy", 96'(s_busy), 96'd1);
    chk("n1_vec", 96'(s_vec), 96'(model_drv(74'h5)));
    @(posedge clk); #1;
    chk("n1_done", 96'(s_done), 96'd1);
    chk("n1_sig", 96'(s_sig), 96'h1021);
    chk("n1_cnt", 96'(s_cnt), 96'd1);
    chk("n1_pass", 96'(s_pass), 96'd1);
    s_exp = 16'h1020;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(posedge clk); #1;
    chk("n1_done2", 96'(s_done), 96'd1);
    chk("n1_fail_pass", 96'(s_pass), 96'd0);

    run('0, 1'b0, 1'b1, 0, 0);
    chk("zero_resp_sig", 96'(sig), 96'd0);
    run('0, 1'b1, 1'b1, 0, 0);
    m = 74'({$urandom, $urandom, $urandom});
    run(m, 1'b0, 1'b1, 0, 0);
    run(74'({$urandom, $urandom, $urandom}), 1'b1, 1'b0, 0, 0);
    run(74'({$urandom, $urandom, $urandom}), 1'b0, 1'b1, 6, 0);
    run(m, 1'b0, 1'b1, 0, 5);
    run(m, 1'b0, 1'b1, 0, 0);
    for (int r = 0; r < 6; r++)
      run(74'({$urandom, $urandom, $urandom}), 1'($urandom), 1'($urandom), 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("vq_drained", 96'(vq.size()), 96'd0);
    chk("rq_drained", 96'(rq.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
